// File: rtl/model_ram_mp.sv
// Multi-port Wishbone RAM model: round-robin arbitration, wait states and incrementing bursts.
// Optional random ack stalls are compiled in with MODEL_RAM_RANDOM_STALL_EN.
//
// state  | meaning
// IDLE   | no transfer; arbitrate among requesting ports
// WAIT   | granted port counting down wait states
// ACK    | acking the granted port, one beat per cycle while bursting
module model_ram_mp #(
  parameter int SIZE_IN_BYTES = 32768,
  parameter int PORTS         = 2,
  parameter int WAIT_STATES   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [PORTS-1:0]      i_wb_cyc,
  input  logic [PORTS-1:0]      i_wb_stb,
  input  logic [PORTS-1:0]      i_wb_we,
  input  logic [32*PORTS-1:0]   i_wb_adr,
  input  logic [4*PORTS-1:0]    i_wb_sel,
  input  logic [32*PORTS-1:0]   i_wb_dat,
  input  logic [3*PORTS-1:0]    i_wb_cti,
  output logic [32*PORTS-1:0]   o_wb_dat,
  output logic [PORTS-1:0]      o_wb_ack
);

  localparam int AW    = $clog2(SIZE_IN_BYTES);
  localparam int WAW   = AW - 2;
  localparam int DEPTH = SIZE_IN_BYTES / 4;
  localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [WAW-1:0]  adr_q, adr_d;
  logic [31:0]     mem_q [DEPTH];

  logic [PORTS-1:0] req;
  logic [PW-1:0]    win;
  logic [WAW-1:0]   win_adr;
  logic             cyc_g, stb_g, we_g;
  logic [2:0]       cti_g;
  logic [3:0]       sel_g;
  logic [31:0]      dat_g;
  logic             stall_w;
  logic             ack_w;
  logic             unused_adr;

  assign req        = i_wb_cyc & i_wb_stb;
  assign unused_adr = ^i_wb_adr;

`ifdef MODEL_RAM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall_w = (lfsr_q[1:0] == 2'b00);
`else
  assign stall_w = 1'b0;
`endif

  // Search starts at the pointer; descending offsets leave the nearest requester as winner.
  always_comb begin
    win = '0;
    for (int c = 0; c < PORTS; c++) begin
      if (ptr_q == PW'(c)) begin
        for (int o = PORTS - 1; o >= 0; o--) begin
          if (req[(c + o) % PORTS]) win = PW'((c + o) % PORTS);
        end
      end
    end
  end

  always_comb begin
    win_adr = '0;
    cyc_g   = 1'b0;
    stb_g   = 1'b0;
    we_g    = 1'b0;
    cti_g   = 3'b000;
    sel_g   = 4'h0;
    dat_g   = 32'h0;
    for (int p = 0; p < PORTS; p++) begin
      if (win == PW'(p)) win_adr = i_wb_adr[32*p+2 +: WAW];
      if (grant_q == PW'(p)) begin
        cyc_g = i_wb_cyc[p];
        stb_g = i_wb_stb[p];
        we_g  = i_wb_we[p];
        cti_g = i_wb_cti[3*p +: 3];
        sel_g = i_wb_sel[4*p +: 4];
        dat_g = i_wb_dat[32*p +: 32];
      end
    end
  end

  // Reset gates the ack so a transfer caught by reset is neither acked nor written.
  assign ack_w = (state_q == S_ACK) && cyc_g && stb_g && !stall_w && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_WAIT;
          grant_d = win;
          cnt_d   = 4'(WAIT_STATES);
          adr_d   = win_adr;
        end
      end
      S_WAIT: begin
        if (!cyc_g)              state_d = S_IDLE;
        else if (cnt_q == 4'd0)  state_d = S_ACK;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      S_ACK: begin
        if (!cyc_g) begin
          state_d = S_IDLE;
        end else if (ack_w) begin
          if (cti_g == 3'b010) begin
            adr_d = adr_q + 1'b1;
          end else begin
            state_d = S_IDLE;
            ptr_d   = (grant_q == PW'(PORTS - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_wb_ack = '0;
    o_wb_dat = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (ack_w && grant_q == PW'(p)) begin
        o_wb_ack[p] = 1'b1;
        if (!we_g) o_wb_dat[32*p +: 32] = mem_q[adr_q];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (ack_w && we_g) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_g[b]) mem_q[adr_q][8*b +: 8] <= dat_g[8*b +: 8];
      end
    end
  end

endmodule
